// File: rtl/rast_hit_pkg.sv
// Shared rasterizer hit definitions: default field widths and the lane
// selector used by the hit arbiter and its lane buffers.
package rast_hit_pkg;

  localparam int SIGFIG_DEF = 24;  // bits per coordinate / color channel
  localparam int AXIS_DEF   = 3;   // x, y, z
  localparam int COLORS_DEF = 3;   // color channels

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  // The lane that gets priority after the given lane wins a grant.
  function automatic lane_e other_lane(input lane_e lane);
    return (lane == LANE_A) ? LANE_B : LANE_A;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Per-lane hit buffer: DEPTH-entry circular FIFO exposing its occupancy and
// head entry. A push into a full FIFO is dropped unless a pop happens on the
// same edge; the drop is reported on a single-cycle strobe.
module hit_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot on the same edge, so a full FIFO can still take a
  // push when it is also being read.
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the tail.
  // NOTE: the storage array is deliberately not reset; the pointers and
  // count define which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hit_arb.sv
// Hit arbiter: merges the hit streams of two sample-test lanes into one
// fragment stream. Each lane lands in its own small FIFO; a round-robin
// arbiter feeds a single output register that holds under downstream halt.
// Upstream is throttled with halt_R18H one entry before a FIFO fills, which
// leaves one entry of slack for a hit already in flight.
module hit_arb
  import rast_hit_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int AXIS   = AXIS_DEF,
  parameter int COLORS = COLORS_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] hit_R18S_a [AXIS],
  input  logic        [SIGFIG-1:0] color_R18U_a [COLORS],
  input  logic                     hit_valid_R18H_a,
  input  logic signed [SIGFIG-1:0] hit_R18S_b [AXIS],
  input  logic        [SIGFIG-1:0] color_R18U_b [COLORS],
  input  logic                     hit_valid_R18H_b,
  input  logic                     halt_RnnH,
  output logic                     halt_R18H,
  output logic signed [SIGFIG-1:0] hit_R19S [AXIS],
  output logic        [SIGFIG-1:0] color_R19U [COLORS],
  output logic                     hit_valid_R19H,
  output logic [31:0]              frag_cnt_R19U,
  output logic                     ovf_err_H
);

  localparam int HW    = SIGFIG * AXIS;             // position field width
  localparam int WIDTH = SIGFIG * (AXIS + COLORS);  // one buffered hit
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HALT_LVL = CW'(DEPTH - 1);

  logic [WIDTH-1:0] wr_a, wr_b;
  logic [WIDTH-1:0] head_a, head_b;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             drop_a, drop_b;
  logic             pop_a, pop_b;

  logic             load_en;
  logic             grant_vld;
  lane_e            grant;
  lane_e            prio_q;
  logic [WIDTH-1:0] grant_data;
  logic [WIDTH-1:0] out_q;
  logic [31:0]      frag_cnt_q;

  // Flatten each lane's position and color fields into one FIFO word:
  // positions in the low bits, colors above them.
  always_comb begin
    wr_a = '0;
    wr_b = '0;
    for (int i = 0; i < AXIS; i++) begin
      wr_a[i*SIGFIG +: SIGFIG] = hit_R18S_a[i];
      wr_b[i*SIGFIG +: SIGFIG] = hit_R18S_b[i];
    end
    for (int i = 0; i < COLORS; i++) begin
      wr_a[HW + i*SIGFIG +: SIGFIG] = color_R18U_a[i];
      wr_b[HW + i*SIGFIG +: SIGFIG] = color_R18U_b[i];
    end
  end

  hit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push    (hit_valid_R18H_a),
    .pop     (pop_a),
    .wr_data (wr_a),
    .head    (head_a),
    .count   (cnt_a),
    .drop    (drop_a)
  );

  hit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push    (hit_valid_R18H_b),
    .pop     (pop_b),
    .wr_data (wr_b),
    .head    (head_b),
    .count   (cnt_b),
    .drop    (drop_b)
  );

  // Throttle both lanes as soon as either buffer reaches its last free slot.
  assign halt_R18H = (cnt_a >= HALT_LVL) | (cnt_b >= HALT_LVL);

  // Round-robin grant: a lone non-empty lane always wins; on a tie the lane
  // named by the priority pointer wins. The output register can accept a
  // new fragment when it is empty or downstream is not halting.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    load_en    = !hit_valid_R19H || !halt_RnnH;
    grant_vld  = 1'b0;
    grant      = LANE_A;
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    grant_data = head_a;
    if (load_en && (cnt_a != '0) && (cnt_b != '0)) begin
      grant_vld = 1'b1;
      grant     = prio_q;
    end else if (load_en && (cnt_a != '0)) begin
      grant_vld = 1'b1;
      grant     = LANE_A;
    end else if (load_en && (cnt_b != '0)) begin
      grant_vld = 1'b1;
      grant     = LANE_B;
    end
    if (grant_vld) begin
      pop_a = (grant == LANE_A);
      pop_b = (grant == LANE_B);
    end
    grant_data = (grant == LANE_B) ? head_b : head_a;
  end

  // Output register: load the granted head, or go invalid when nothing is
  // queued; hold everything while a valid fragment is halted downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q          <= '0;
      hit_valid_R19H <= 1'b0;
    end else if (load_en) begin
      hit_valid_R19H <= grant_vld;
      if (grant_vld) out_q <= grant_data;
    end
  end

  // Priority pointer moves to the other lane only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= LANE_A;
    end else if (grant_vld) begin
      prio_q <= other_lane(grant);
    end
  end

  // Delivered-fragment counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frag_cnt_q <= '0;
    end else if (grant_vld) begin
      frag_cnt_q <= frag_cnt_q + 32'd1;
    end
  end

  // Sticky overflow: any dropped write latches the flag until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err_H <= 1'b0;
    end else if (drop_a || drop_b) begin
      ovf_err_H <= 1'b1;
    end
  end

  assign frag_cnt_R19U = frag_cnt_q;

  // Split the output register back into position and color fields.
  always_comb begin
    for (int i = 0; i < AXIS; i++) begin
      hit_R19S[i] = out_q[i*SIGFIG +: SIGFIG];
    end
    for (int i = 0; i < COLORS; i++) begin
      color_R19U[i] = out_q[HW + i*SIGFIG +: SIGFIG];
    end
  end

endmodule

// File: tb/tb_hit_arb.sv
// Self-checking bench for hit_arb: a queue-based model of the two lane
// buffers and output register is compared with the DUT on every cycle,
// alongside directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_hit_arb;

  localparam int SIGFIG = 24;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [COLORS-1:0][SIGFIG-1:0] col;
    logic [AXIS-1:0][SIGFIG-1:0]   pos;
  } frag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [SIGFIG-1:0] hit_a [AXIS];
  logic signed [SIGFIG-1:0] hit_b [AXIS];
  logic signed [SIGFIG-1:0] hit_o [AXIS];
  logic        [SIGFIG-1:0] col_a [COLORS];
  logic        [SIGFIG-1:0] col_b [COLORS];
  logic        [SIGFIG-1:0] col_o [COLORS];
  logic va = 1'b0, vb = 1'b0, halt_in = 1'b0;
  logic halt_out, vo, ovf;
  logic [31:0] fcnt;
  frag_t fa = '0, fb = '0, act;

  int n_checks = 0;
  int n_err    = 0;

  hit_arb #(
    .SIGFIG (SIGFIG),
    .AXIS   (AXIS),
    .COLORS (COLORS),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .hit_R18S_a       (hit_a),
    .color_R18U_a     (col_a),
    .hit_valid_R18H_a (va),
    .hit_R18S_b       (hit_b),
    .color_R18U_b     (col_b),
    .hit_valid_R18H_b (vb),
    .halt_RnnH        (halt_in),
    .halt_R18H        (halt_out),
    .hit_R19S         (hit_o),
    .color_R19U       (col_o),
    .hit_valid_R19H   (vo),
    .frag_cnt_R19U    (fcnt),
    .ovf_err_H        (ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    act = '0;
    for (int i = 0; i < AXIS; i++) begin
      hit_a[i]   = fa.pos[i];
      hit_b[i]   = fb.pos[i];
      act.pos[i] = hit_o[i];
    end
    for (int i = 0; i < COLORS; i++) begin
      col_a[i]   = fa.col[i];
      col_b[i]   = fb.col[i];
      act.col[i] = col_o[i];
    end
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkf(input string name, input frag_t got, input frag_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Distinct, recognisable hit for lane (0=A, 1=B) and sequence index.
  function automatic frag_t mk(input int lane, input int idx);
    frag_t f;
    for (int i = 0; i < AXIS; i++)
      f.pos[i] = SIGFIG'((lane + 1) * 32'h10000 + idx * 16 + i);
    for (int i = 0; i < COLORS; i++)
      f.col[i] = SIGFIG'(32'h800000 + (lane + 1) * 32'h1000 + idx * 16 + i);
    return f;
  endfunction

  // ---------------- behavioural model ----------------
  frag_t       mqa[$], mqb[$], m_log[$];
  bit          m_ov   = 1'b0;
  frag_t       m_od   = '0;
  logic [31:0] m_cnt  = '0;
  bit          m_prio = 1'b0;   // 0: lane A wins the next tie
  bit          m_ovf  = 1'b0;

  always @(posedge clk) begin : model
    bit    le, pa, pb;
    frag_t d;
    if (rst) begin
      mqa.delete(); mqb.delete(); m_log.delete();
      m_ov = 1'b0; m_od = '0; m_cnt = '0; m_prio = 1'b0; m_ovf = 1'b0;
    end else begin
      le = !m_ov || !halt_in;
      pa = 1'b0;
      pb = 1'b0;
      if (le) begin
        if (mqa.size() > 0 && mqb.size() > 0) begin
          pa = (m_prio == 1'b0);
          pb = !pa;
        end else begin
          pa = (mqa.size() > 0);
          pb = (mqb.size() > 0);
        end
      end
      d = '0;
      if (pa) d = mqa.pop_front();
      else if (pb) d = mqb.pop_front();
      if (va) begin
        if (mqa.size() < DEPTH) mqa.push_back(fa); else m_ovf = 1'b1;
      end
      if (vb) begin
        if (mqb.size() < DEPTH) mqb.push_back(fb); else m_ovf = 1'b1;
      end
      if (le) begin
        m_ov = pa || pb;
        if (pa || pb) begin
          m_od   = d;
          m_cnt  = m_cnt + 32'd1;
          m_prio = pa;
          m_log.push_back(d);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check32("valid", 32'(vo), 32'(m_ov));
    check32("halt_r18", 32'(halt_out),
            32'((mqa.size() >= DEPTH - 1) || (mqb.size() >= DEPTH - 1)));
    check32("ovf", 32'(ovf), 32'(m_ovf));
    check32("frag_cnt", fcnt, m_cnt);
    checkf("data", act, m_od);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; va = 1'b0; vb = 1'b0; halt_in = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    va = 1'b0; vb = 1'b0; halt_in = 1'b0;
    n = 0;
    while ((mqa.size() != 0 || mqb.size() != 0 || m_ov) && n < 60) begin
      cyc();
      n++;
    end
    if (n >= 60) check32("drain_timeout", 32'd0, 32'd1);
  endtask

  int    ia, ib, nb;
  bit    hs;
  frag_t f123;

  initial begin
    // Reset state
    cyc(); cyc();
    check32("rst_valid", 32'(vo), 32'd0);
    check32("rst_cnt", fcnt, 32'd0);
    check32("rst_halt", 32'(halt_out), 32'd0);
    check32("rst_ovf", 32'(ovf), 32'd0);
    checkf("rst_data", act, '0);
    rst = 1'b0;

    // Single A hit (1,2,3): two-cycle latency
    cyc();
    f123 = mk(0, 7);
    f123.pos[0] = 24'd1; f123.pos[1] = 24'd2; f123.pos[2] = 24'd3;
    fa = f123; va = 1'b1;
    cyc();
    va = 1'b0;
    check32("lat_n1_valid", 32'(vo), 32'd0);
    cyc();
    check32("lat_n2_valid", 32'(vo), 32'd1);
    checkf("lat_n2_data", act, f123);
    check32("lat_n2_cnt", fcnt, 32'd1);
    drain();

    // Both lanes streaming, upstream honouring halt_R18H
    do_reset();
    ia = 0; ib = 0; nb = 0; hs = 1'b0;
    while ((ia < 8 || ib < 8) && nb < 100) begin
      if (halt_out) hs = 1'b1;
      if (!halt_out && ia < 8) begin fa = mk(0, ia); va = 1'b1; ia++; end else va = 1'b0;
      if (!halt_out && ib < 8) begin fb = mk(1, ib); vb = 1'b1; ib++; end else vb = 1'b0;
      cyc();
      nb++;
    end
    check32("rr_sent", 32'(ia + ib), 32'd16);
    drain();
    check32("rr_log_size", 32'(m_log.size()), 32'd16);
    checkf("rr_order0", m_log[0], mk(0, 0));
    checkf("rr_order1", m_log[1], mk(1, 0));
    checkf("rr_order2", m_log[2], mk(0, 1));
    checkf("rr_order3", m_log[3], mk(1, 1));
    check32("rr_cnt", fcnt, 32'd16);
    check32("rr_ovf", 32'(ovf), 32'd0);
    check32("rr_halt_seen", 32'(hs), 32'd1);

    // Downstream halt with a valid fragment on the output
    do_reset();
    fa = mk(0, 0); va = 1'b1;
    cyc();
    va = 1'b0;
    cyc();
    halt_in = 1'b1;
    ia = 1; ib = 0;
    for (int k = 0; k < 6; k++) begin
      check32("hold_valid", 32'(vo), 32'd1);
      checkf("hold_data", act, mk(0, 0));
      if (!halt_out) begin
        fa = mk(0, ia); fb = mk(1, ib); va = 1'b1; vb = 1'b1; ia++; ib++;
      end else begin
        va = 1'b0; vb = 1'b0;
      end
      cyc();
    end
    va = 1'b0; vb = 1'b0;
    check32("hold_halt_r18", 32'(halt_out), 32'd1);
    checkf("hold_data_end", act, mk(0, 0));
    drain();
    check32("hold_cnt", fcnt, 32'd7);

    // Lane A ignores halt_R18H until the buffer overflows
    do_reset();
    halt_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fa = mk(0, k); va = 1'b1;
      cyc();
      if (k == 4) check32("ovf_before", 32'(ovf), 32'd0);
      if (k == 5) check32("ovf_after", 32'(ovf), 32'd1);
    end
    va = 1'b0;
    cyc();
    drain();
    check32("ovf_delivered", fcnt, 32'd5);
    check32("ovf_log_size", 32'(m_log.size()), 32'd5);
    checkf("ovf_last", m_log[4], mk(0, 4));
    check32("ovf_sticky", 32'(ovf), 32'd1);
    do_reset();
    check32("ovf_cleared", 32'(ovf), 32'd0);

    // Reset with entries in flight, then a tie goes to lane A
    halt_in = 1'b1;
    fa = mk(0, 0); fb = mk(1, 0); va = 1'b1; vb = 1'b1;
    cyc();
    fa = mk(0, 1); fb = mk(1, 1);
    cyc();
    va = 1'b0; vb = 1'b0;
    cyc();
    check32("mid_queued", 32'(mqa.size() + mqb.size()), 32'd3);
    rst = 1'b1; halt_in = 1'b0; fa = mk(0, 9); va = 1'b1;
    cyc();
    rst = 1'b0;
    check32("mid_rst_valid", 32'(vo), 32'd0);
    check32("mid_rst_cnt", fcnt, 32'd0);
    check32("mid_rst_halt", 32'(halt_out), 32'd0);
    fa = mk(0, 5); fb = mk(1, 5); va = 1'b1; vb = 1'b1;
    cyc();
    va = 1'b0; vb = 1'b0;
    check32("tie_n1_valid", 32'(vo), 32'd0);
    cyc();
    check32("tie_valid", 32'(vo), 32'd1);
    checkf("tie_lane_a", act, mk(0, 5));
    drain();
    check32("tie_cnt", fcnt, 32'd2);

    // Fragment counter wrap
    @(posedge clk);
    #2;
    force dut.frag_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.frag_cnt_q;
    cyc();
    check32("wrap_preset", fcnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      fa = mk(0, k); va = 1'b1;
      cyc();
    end
    va = 1'b0;
    drain();
    check32("wrap_cnt", fcnt, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hit_arb.md
HIT_ARB -- requirements
Module: hit_arb

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, bits per coordinate/color.
REQ-002 SHALL have parameter AXIS, default 3, axes per hit (x,y,z).
REQ-003 SHALL have parameter COLORS, default 3, color channels.
REQ-004 SHALL have parameter DEPTH, default 4, entries per lane FIFO (power of 2, >=4).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port hit_R18S_a  input  signed [SIGFIG-1:0] x AXIS  lane-A hit position.
REQ-008 SHALL have port color_R18U_a  input  [SIGFIG-1:0] x COLORS  lane-A hit color.
REQ-009 SHALL have port hit_valid_R18H_a  input  1  lane-A hit valid.
REQ-010 SHALL have ports hit_R18S_b, color_R18U_b, hit_valid_R18H_b  input  same widths  lane-B equivalents.
REQ-011 SHALL have port halt_RnnH  input  1  downstream stall; output must hold.
REQ-012 SHALL have port halt_R18H  output  1  stall request to both sample-test lanes.
REQ-013 SHALL have ports hit_R19S, color_R19U  output  same widths  merged fragment.
REQ-014 SHALL have port hit_valid_R19H  output  1  merged fragment valid.
REQ-015 SHALL have port frag_cnt_R19U  output  32  fragments delivered since reset.
REQ-016 SHALL have port ovf_err_H  output  1  sticky overflow flag.

Function
REQ-017 SHALL push each valid lane input into that lane's FIFO at the clock edge ending its cycle, both lanes independently in the same edge.
REQ-018 SHALL drive halt_R18H = (cnt_a >= DEPTH-1) | (cnt_b >= DEPTH-1), combinational from registered counts; inputs arriving while halt_R18H is high SHALL still be accepted (one-entry slack).
REQ-019 SHALL drop a write to a FIFO holding DEPTH entries with no same-edge pop, leave contents unchanged, and set ovf_err_H; ovf_err_H SHALL stay high until reset.
REQ-020 SHALL treat same-edge push and pop on one lane as count unchanged, data order preserved.
REQ-021 SHALL, each edge where output register is empty or halt_RnnH is low, pop one head entry into the output register if any FIFO is non-empty; else hit_valid_R19H SHALL fall (when halt_RnnH low).
REQ-022 SHALL arbitrate round-robin: only one lane non-empty -> that lane; both non-empty -> lane opposite last granted; priority pointer updates only on a grant.
REQ-023 SHALL hold hit_R19S, color_R19U, hit_valid_R19H unchanged while halt_RnnH is high and hit_valid_R19H is high.
REQ-024 SHALL give minimum latency 2 cycles: input valid in cycle N appears on outputs in cycle N+2 when FIFO empty and no halt.
REQ-025 SHALL preserve per-lane order; no entry SHALL be duplicated or lost except via REQ-019.
REQ-026 SHALL increment frag_cnt_R19U by 1 on every edge a fragment loads into the output register, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-027 SHALL on rst high at an edge: clear both FIFO counts/pointers, hit_valid_R19H=0, hit_R19S=0, color_R19U=0, frag_cnt_R19U=0, ovf_err_H=0, priority pointer to lane A (A wins first tie); halt_R18H thus 0.
REQ-028 SHALL discard all in-flight entries on reset mid-operation and ignore lane inputs during the reset edge.

Structure
REQ-029 SHALL take SIGFIG/AXIS/COLORS defaults and lane-select enum (LANE_A, LANE_B) from shared package rast_hit_pkg.
REQ-030 SHALL implement each lane buffer as one sub-module hit_fifo (count, head data, push, pop), instantiated twice.

Verification
REQ-031 Single A hit (1,2,3) in cycle 5, no halt -> output valid cycle 7 with (1,2,3), frag_cnt=1.
REQ-032 A and B valid both every cycle for 8 cycles, no halt -> outputs alternate A0,B0,A1,B1...; halt_R18H rises once cnt reaches 3; no ovf_err_H; frag_cnt=16 at drain.
REQ-033 halt_RnnH high 6 cycles with output valid -> output bits frozen, counts grow to DEPTH-1, halt_R18H high; release -> all entries delivered in order.
REQ-034 Lane A writes ignoring halt_R18H until cnt_a=4, one more write -> ovf_err_H=1, entry dropped, stays 1 until rst.
REQ-035 rst asserted with 3 entries queued -> next cycle hit_valid_R19H=0, frag_cnt=0, halt_R18H=0; next tie grants lane A.
REQ-036 frag_cnt forced near 0xFFFFFFFE, deliver 3 fragments -> counter reads 0x00000001.
